// File: rtl/patch_lut_engine_if.sv
// rtl/patch_lut_engine_if.sv - lookup request and result stream bundle for patch_lut_engine
// slave is the engine side; master is whoever feeds vectors and drains results.
interface patch_lut_engine_if #(
  parameter int N_IN  = 3,
  parameter int N_TGT = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [N_IN-1:0]  out_vec;
  logic [N_TGT-1:0] t_out;
  logic             out_last;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec, t_out, out_last
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec, t_out, out_last
  );
endinterface

// File: rtl/patch_lut_engine.sv
// rtl/patch_lut_engine.sv - reprogrammable truth-table patch engine with lookup and sweep modes
// One output register is shared by lookups and sweep beats; a sweep enumerates every index in order.
module patch_lut_engine #(
  parameter int N_IN  = 3,
  parameter int N_TGT = 1,
  parameter int TGT_W = (N_TGT > 1) ? $clog2(N_TGT) : 1,
  parameter logic [N_TGT*(2**N_IN)-1:0] INIT_LUT = 8'hDB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [TGT_W-1:0] cfg_tgt,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  patch_lut_engine_if.slave s_if
);
  localparam int DEPTH = 1 << N_IN;

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [1:0]               r_rst_sync;
  logic                     w_rst_n;
  logic [N_TGT*DEPTH-1:0]   r_lut;
  logic [N_IN:0]            r_cnt;
  logic                     w_slot_free;
  logic                     w_in_fire;
  logic                     w_sweep_load;
  logic                     w_last_acc;
  logic                     w_wr_en;
  logic [N_IN-1:0]          w_idx;
  logic [N_TGT-1:0]         w_lookup;

  // Reset asserts immediately but releases on a clock edge so no flop sees a runt release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_slot_free = !s_if.out_valid || s_if.out_ready;
  assign w_in_fire   = s_if.in_valid && s_if.in_ready;
  assign w_last_acc  = s_if.out_valid && s_if.out_ready && s_if.out_last;
  assign w_wr_en     = cfg_we && cfg_ready && (int'(cfg_tgt) < N_TGT);
  assign w_idx       = (r_state == ST_SWEEP) ? r_cnt[N_IN-1:0] : s_if.in_vec;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    cfg_ready     = 1'b0;
    sweep_busy    = 1'b0;
    sweep_done    = 1'b0;
    s_if.in_ready = 1'b0;
    w_sweep_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cfg_ready     = 1'b1;
        s_if.in_ready = !sweep_start && w_slot_free;
        if (sweep_start) w_state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        sweep_busy = 1'b1;
        // r_cnt[N_IN] marks that every beat has been loaded; wait for the last to drain.
        w_sweep_load = w_slot_free && !r_cnt[N_IN];
        if (w_last_acc) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        sweep_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_lookup = '0;
    for (int t = 0; t < N_TGT; t++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (w_idx == N_IN'(a)) w_lookup[t] = r_lut[t*DEPTH + a];
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_lut <= INIT_LUT;
    end else begin
      for (int t = 0; t < N_TGT; t++) begin
        for (int a = 0; a < DEPTH; a++) begin
          if (w_wr_en && (int'(cfg_tgt) == t) && (cfg_addr == N_IN'(a)))
            r_lut[t*DEPTH + a] <= cfg_bit;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt          <= '0;
      s_if.out_valid <= 1'b0;
      s_if.out_vec   <= '0;
      s_if.t_out     <= '0;
      s_if.out_last  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && sweep_start)
        r_cnt <= '0;
      else if (w_sweep_load)
        r_cnt <= r_cnt + (N_IN+1)'(1);
      else if (r_state == ST_SWEEP && w_last_acc)
        r_cnt <= '0;

      if (w_in_fire) begin
        s_if.out_valid <= 1'b1;
        s_if.out_vec   <= s_if.in_vec;
        s_if.t_out     <= w_lookup;
        s_if.out_last  <= 1'b0;
      end else if (w_sweep_load) begin
        s_if.out_valid <= 1'b1;
        s_if.out_vec   <= r_cnt[N_IN-1:0];
        s_if.t_out     <= w_lookup;
        s_if.out_last  <= (r_cnt[N_IN-1:0] == N_IN'(DEPTH-1));
      end else if (s_if.out_ready) begin
        s_if.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_patch_lut_engine.sv
// tb/tb_patch_lut_engine.sv - randomized scoreboard bench for patch_lut_engine
// Expected beats come from a truth-table model and a queue of promised results.
module tb_patch_lut_engine;
  localparam int N_IN  = 3;
  localparam int N_TGT = 1;
  localparam int TGT_W = 1;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [N_IN-1:0]  vec;
    logic [N_TGT-1:0] t;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [TGT_W-1:0] cfg_tgt = '0;
  logic [N_IN-1:0]  cfg_addr = '0;
  logic             cfg_bit = 1'b0;
  logic             cfg_ready;
  logic             sweep_start = 1'b0;
  logic             sweep_busy;
  logic             sweep_done;

  int    n_vec = 0;
  int    n_err = 0;
  bit    m_lut [N_TGT][DEPTH];
  int    phase;
  int    sweep_pops;
  beat_t q[$];
  bit    prev_in_fire;
  bit    prev_stall;
  beat_t prev_beat;

  always #5 clk = ~clk;

  patch_lut_engine_if #(.N_IN(N_IN), .N_TGT(N_TGT)) ifc ();

  patch_lut_engine #(
    .N_IN(N_IN), .N_TGT(N_TGT), .TGT_W(TGT_W), .INIT_LUT(8'hDB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_tgt(cfg_tgt), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .s_if(ifc.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_TGT-1:0] lookup_model(input logic [N_IN-1:0] v);
    logic [N_TGT-1:0] r;
    for (int t = 0; t < N_TGT; t++) r[t] = m_lut[t][v];
    return r;
  endfunction

  task automatic init_model();
    for (int i = 0; i < DEPTH; i++) begin
      bit a, b, c;
      a = i[2]; b = i[1]; c = i[0];
      m_lut[0][i] = ~((a & c & ~b) | (~a & b & ~c));
    end
    q.delete();
    phase        = 0;
    sweep_pops   = 0;
    prev_in_fire = 0;
    prev_stall   = 0;
  endtask

  task automatic drive_idle();
    ifc.in_valid  = 1'b0;
    ifc.in_vec    = '0;
    ifc.out_ready = 1'b1;
    cfg_we        = 1'b0;
    sweep_start   = 1'b0;
  endtask

  // Called at a falling edge with inputs already set; checks this cycle, advances the model.
  task automatic step();
    logic  exp_rdy;
    logic  popped_last;
    beat_t e;
    #1;
    chk("cfg_ready", cfg_ready, phase == 0);
    chk("sweep_busy", sweep_busy, phase == 1);
    chk("sweep_done", sweep_done, phase == 2);
    exp_rdy = (phase == 0) && !sweep_start && (!ifc.out_valid || ifc.out_ready);
    chk("in_ready", ifc.in_ready, exp_rdy);
    if (prev_in_fire) chk("latency", ifc.out_valid, 1);
    if (prev_stall) begin
      chk("hold_valid", ifc.out_valid, 1);
      chk("hold_vec", ifc.out_vec, prev_beat.vec);
      chk("hold_t", ifc.t_out, prev_beat.t);
      chk("hold_last", ifc.out_last, prev_beat.last);
    end
    popped_last = 1'b0;
    if (ifc.out_valid && ifc.out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out_vec", ifc.out_vec, e.vec);
        chk("t_out", ifc.t_out, e.t);
        chk("out_last", ifc.out_last, e.last);
        popped_last = e.last;
        if (phase == 1) sweep_pops++;
      end
    end
    prev_stall     = ifc.out_valid && !ifc.out_ready;
    prev_beat.vec  = ifc.out_vec;
    prev_beat.t    = ifc.t_out;
    prev_beat.last = ifc.out_last;
    prev_in_fire   = ifc.in_valid && ifc.in_ready;
    if (prev_in_fire) begin
      e.vec  = ifc.in_vec;
      e.t    = lookup_model(ifc.in_vec);
      e.last = 1'b0;
      q.push_back(e);
    end
    if (phase == 0 && cfg_we && int'(cfg_tgt) < N_TGT) m_lut[cfg_tgt][cfg_addr] = cfg_bit;
    case (phase)
      0: if (sweep_start) begin
        for (int v = 0; v < DEPTH; v++) begin
          e.vec  = N_IN'(v);
          e.t    = lookup_model(N_IN'(v));
          e.last = (v == DEPTH - 1);
          q.push_back(e);
        end
        phase      = 1;
        sweep_pops = 0;
      end
      1: if (popped_last) phase = 2;
      default: phase = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((phase != 0 || q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    init_model();
  endtask

  initial begin
    drive_idle();
    init_model();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_vec", ifc.out_vec, 0);
    chk("rst_t_out", ifc.t_out, 0);
    chk("rst_out_last", ifc.out_last, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Every index once, back to back.
    for (int v = 0; v < DEPTH; v++) begin
      ifc.in_valid = 1'b1;
      ifc.in_vec   = N_IN'(v);
      step();
    end
    drive_idle();
    run_until_idle("lookups", 10);

    // Write and lookup of the same entry in one cycle, then re-lookup.
    ifc.in_valid = 1'b1; ifc.in_vec = 3'd2;
    cfg_we = 1'b1; cfg_tgt = '0; cfg_addr = 3'd2; cfg_bit = 1'b1;
    step();
    cfg_we = 1'b0;
    step();
    drive_idle();
    run_until_idle("wr_collide", 10);

    // Backpressure with a continuously offered stream.
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ifc.in_vec = N_IN'($urandom_range(0, DEPTH - 1));
      step();
    end
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ifc.in_vec = N_IN'($urandom_range(0, DEPTH - 1));
      step();
    end
    drive_idle();
    run_until_idle("backpressure", 10);

    // Sweep requested alongside a lookup, re-requested mid-sweep, random drain.
    sweep_start  = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_vec   = 3'd5;
    step();
    for (int k = 0; k < 200 && phase != 0; k++) begin
      sweep_start   = (k == 4);
      cfg_we        = 1'b1;
      cfg_addr      = N_IN'($urandom_range(0, DEPTH - 1));
      cfg_bit       = 1'($urandom_range(0, 1));
      ifc.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("sweep_beats", sweep_pops, DEPTH);
    drive_idle();
    run_until_idle("sweep", 50);

    // Mixed random traffic.
    for (int k = 0; k < 400; k++) begin
      ifc.in_valid  = 1'($urandom_range(0, 1));
      ifc.in_vec    = N_IN'($urandom_range(0, DEPTH - 1));
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      cfg_we        = ($urandom_range(0, 3) == 0);
      cfg_tgt       = TGT_W'($urandom_range(0, 1));
      cfg_addr      = N_IN'($urandom_range(0, DEPTH - 1));
      cfg_bit       = 1'($urandom_range(0, 1));
      sweep_start   = ($urandom_range(0, 49) == 0);
      step();
    end
    drive_idle();
    run_until_idle("random", 100);

    // Reprogram, then reset in the middle of a sweep.
    for (int a = 0; a < DEPTH; a++) begin
      cfg_we = 1'b1; cfg_tgt = '0; cfg_addr = N_IN'(a); cfg_bit = 1'(a % 2);
      step();
    end
    cfg_we = 1'b0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int k = 0; k < 50 && sweep_pops < 4; k++) step();
    chk("pre_reset_pops", sweep_pops, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", ifc.out_valid, 0);
    chk("async_busy", sweep_busy, 0);
    chk("async_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    apply_reset();
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    run_until_idle("post_reset_sweep", 50);
    chk("post_reset_beats", sweep_pops, DEPTH);

    drive_idle();
    repeat (3) step();
    chk("drain_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
